// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - fetch-side bundle: imem port, redirect/stall controls, IF/ID outputs
interface instruction_fetch_unit_if;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        jump;
    logic [15:0] jump_target;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus2;
    logic        if_valid;
    logic        halted;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  stall,
        input  branch_taken,
        input  branch_target,
        input  jump,
        input  jump_target,
        output if_instr,
        output if_pc,
        output if_pc_plus2,
        output if_valid,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output stall,
        output branch_taken,
        output branch_target,
        output jump,
        output jump_target,
        input  if_instr,
        input  if_pc,
        input  if_pc_plus2,
        input  if_valid,
        input  halted
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner and IF/ID register with stall, redirect squash and HALT
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instruction_fetch_unit_if.master  bus
);
    typedef enum logic {RUN, HALTED} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] ir_pc_q, ir_pc_d;
    logic        valid_q, valid_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            ir_pc_q <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ir_pc_d = ir_pc_q;
        valid_d = valid_q;
        case (state_q)
            RUN: begin
                // Redirects outrank stall so a taken branch never waits on decode.
                if (bus.branch_taken) begin
                    pc_d    = bus.branch_target & 16'hFFFE;
                    valid_d = 1'b0;
                end else if (bus.jump) begin
                    pc_d    = bus.jump_target & 16'hFFFE;
                    valid_d = 1'b0;
                end else if (!bus.stall) begin
                    ir_d    = bus.imem_instr;
                    ir_pc_d = pc_q;
                    valid_d = 1'b1;
                    if (bus.imem_instr[15:12] == HALT_OPCODE) begin
                        state_d = HALTED;
                    end else begin
                        pc_d = pc_q + 16'd2;
                    end
                end
            end
            HALTED: begin
                // HALT stays visible while decode stalls, then drains as a bubble.
                if (!bus.stall) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign bus.imem_addr   = pc_q;
    assign bus.if_instr    = ir_q;
    assign bus.if_pc       = ir_pc_q;
    assign bus.if_pc_plus2 = ir_pc_q + 16'd2;
    assign bus.if_valid    = valid_q;
    assign bus.halted      = (state_q == HALTED);
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed checks of fetch, stall, redirect, wrap and HALT
module tb_instruction_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [15:0] mem [256];

    always #5 clk = ~clk;

    instruction_fetch_unit_if bus0 ();
    instruction_fetch_unit_if bus1 ();

    instruction_fetch_unit #(.RESET_PC(16'h0000), .HALT_OPCODE(4'hF)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus0.master)
    );
    instruction_fetch_unit #(.RESET_PC(16'hFFFC), .HALT_OPCODE(4'hF)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus(bus1.master)
    );

    assign bus0.imem_instr = mem[bus0.imem_addr[8:1]];
    assign bus1.imem_instr = mem[bus1.imem_addr[8:1]];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]    = 16'h1111;
        mem[1]    = 16'h2222;
        mem[2]    = 16'h3333;
        mem[3]    = 16'h4444;
        mem[8]    = 16'h5555;
        mem[9]    = 16'h6666;
        mem[8'hFE] = 16'hAAAA;
        mem[8'hFF] = 16'hBBBB;
        bus0.stall = 0; bus0.branch_taken = 0; bus0.branch_target = 0;
        bus0.jump = 0; bus0.jump_target = 0;
        bus1.stall = 0; bus1.branch_taken = 0; bus1.branch_target = 0;
        bus1.jump = 0; bus1.jump_target = 0;

        // reset state
        tick();
        tick();
        chk("rst_addr",   bus0.imem_addr, 16'h0000);
        chk("rst_instr",  bus0.if_instr, 16'h0000);
        chk("rst_pc",     bus0.if_pc, 16'h0000);
        chk("rst_plus2",  bus0.if_pc_plus2, 16'h0002);
        chk("rst_valid",  {15'b0, bus0.if_valid}, 16'h0000);
        chk("rst_halted", {15'b0, bus0.halted}, 16'h0000);
        chk("wrap_rst_addr", bus1.imem_addr, 16'hFFFC);
        rst_n = 1'b1;

        // sequential fetch (and wrap instance in parallel)
        tick();
        chk("seq0_instr", bus0.if_instr, 16'h1111);
        chk("seq0_pc",    bus0.if_pc, 16'h0000);
        chk("seq0_valid", {15'b0, bus0.if_valid}, 16'h0001);
        chk("seq0_addr",  bus0.imem_addr, 16'h0002);
        chk("wrap0_pc",   bus1.if_pc, 16'hFFFC);
        chk("wrap0_instr", bus1.if_instr, 16'hAAAA);
        tick();
        chk("seq1_instr", bus0.if_instr, 16'h2222);
        chk("seq1_pc",    bus0.if_pc, 16'h0002);
        chk("seq1_addr",  bus0.imem_addr, 16'h0004);
        chk("wrap1_pc",   bus1.if_pc, 16'hFFFE);
        chk("wrap1_plus2", bus1.if_pc_plus2, 16'h0000);
        chk("wrap1_addr", bus1.imem_addr, 16'h0000);

        // stall two cycles while if_instr = 2222
        bus0.stall = 1'b1;
        tick();
        chk("wrap2_pc",   bus1.if_pc, 16'h0000);
        chk("wrap2_instr", bus1.if_instr, 16'h1111);
        for (int i = 0; i < 2; i++) begin
            if (i == 1) tick();
            chk("stall_instr", bus0.if_instr, 16'h2222);
            chk("stall_pc",    bus0.if_pc, 16'h0002);
            chk("stall_addr",  bus0.imem_addr, 16'h0004);
            chk("stall_valid", {15'b0, bus0.if_valid}, 16'h0001);
        end
        bus0.stall = 1'b0;
        tick();
        chk("post_stall_instr", bus0.if_instr, 16'h3333);
        chk("post_stall_pc",    bus0.if_pc, 16'h0004);
        tick();
        chk("post_stall_instr2", bus0.if_instr, 16'h4444);
        chk("post_stall_addr",   bus0.imem_addr, 16'h0008);

        // redirect: branch beats jump, bit0 cleared
        do_reset();
        tick();
        tick();
        chk("redir_pre_addr", bus0.imem_addr, 16'h0004);
        bus0.branch_taken = 1'b1; bus0.branch_target = 16'h0011;
        bus0.jump = 1'b1;         bus0.jump_target = 16'h0020;
        tick();
        bus0.branch_taken = 1'b0; bus0.jump = 1'b0;
        chk("redir_addr",  bus0.imem_addr, 16'h0010);
        chk("redir_valid", {15'b0, bus0.if_valid}, 16'h0000);
        tick();
        chk("redir_instr", bus0.if_instr, 16'h5555);
        chk("redir_pc",    bus0.if_pc, 16'h0010);
        chk("redir_vld1",  {15'b0, bus0.if_valid}, 16'h0001);
        chk("redir_next",  bus0.imem_addr, 16'h0012);

        // redirect during stall wins over stall
        bus0.stall = 1'b1; bus0.jump = 1'b1; bus0.jump_target = 16'h0003;
        tick();
        bus0.stall = 1'b0; bus0.jump = 1'b0;
        chk("stall_jump_addr",  bus0.imem_addr, 16'h0002);
        chk("stall_jump_valid", {15'b0, bus0.if_valid}, 16'h0000);
        tick();
        chk("stall_jump_instr", bus0.if_instr, 16'h2222);
        chk("stall_jump_pc",    bus0.if_pc, 16'h0002);

        // HALT at address 6
        mem[3] = 16'hF000;
        do_reset();
        tick(); tick(); tick();
        chk("halt_pre_addr", bus0.imem_addr, 16'h0006);
        tick();
        chk("halt_instr", bus0.if_instr, 16'hF000);
        chk("halt_valid", {15'b0, bus0.if_valid}, 16'h0001);
        chk("halt_addr",  bus0.imem_addr, 16'h0006);
        tick();
        chk("halted_flag",  {15'b0, bus0.halted}, 16'h0001);
        chk("halted_valid", {15'b0, bus0.if_valid}, 16'h0000);
        chk("halted_addr",  bus0.imem_addr, 16'h0006);
        bus0.jump = 1'b1; bus0.jump_target = 16'h0010;
        tick();
        bus0.jump = 1'b0;
        chk("halted_jump_addr", bus0.imem_addr, 16'h0006);
        chk("halted_jump_flag", {15'b0, bus0.halted}, 16'h0001);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("halt_rst_addr", bus0.imem_addr, 16'h0000);
        chk("halt_rst_flag", {15'b0, bus0.halted}, 16'h0000);

        // HALT squashed by same-cycle jump
        tick(); tick(); tick();
        chk("squash_pre_addr", bus0.imem_addr, 16'h0006);
        bus0.jump = 1'b1; bus0.jump_target = 16'h0010;
        tick();
        bus0.jump = 1'b0;
        chk("squash_halted", {15'b0, bus0.halted}, 16'h0000);
        chk("squash_addr",   bus0.imem_addr, 16'h0010);
        chk("squash_valid",  {15'b0, bus0.if_valid}, 16'h0000);
        tick();
        chk("squash_instr",  bus0.if_instr, 16'h5555);
        chk("squash_vld1",   {15'b0, bus0.if_valid}, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Drives the instruction memory from the fetch side: owns the program counter, presents `imem_addr` to the combinational instruction memory, and registers the returned word into the IF/ID instruction register. Handles sequential fetch, stalls, branch/jump redirects with wrong-path squash, and HALT detection. Sits between the instruction memory and the decode stage of the simplified 16-bit MIPS pipeline.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset
- `HALT_OPCODE`, 4'hF, value of instr[15:12] identifying HALT
- `clk`  in  1  single clock; all state changes on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `imem_addr`  out  16  byte address to instruction memory; equals PC register
- `imem_instr`  in  16  instruction word returned combinationally for `imem_addr`
- `stall`  in  1  decode cannot accept; hold PC and IR
- `branch_taken`  in  1  redirect to `branch_target` this cycle
- `branch_target`  in  16  branch destination
- `jump`  in  1  redirect to `jump_target` this cycle
- `jump_target`  in  16  jump destination
- `if_instr`  out  16  registered instruction to decode
- `if_pc`  out  16  address `if_instr` was fetched from
- `if_pc_plus2`  out  16  `if_pc + 2`, for link/branch base
- `if_valid`  out  1  `if_instr` is a real, non-squashed instruction
- `halted`  out  1  HALT has been delivered; fetch stopped

## Operation
- State: PC (16b), IR, IR_PC, valid, FSM {RUN, HALTED}.
- Reset (rst_n=0 at edge): PC=RESET_PC, if_instr=16'h0000, if_pc=16'h0000, if_pc_plus2=16'h0002, if_valid=0, halted=0, state=RUN. Reset overrides every other input, including in HALTED.
- RUN, next-PC priority (highest first):
  - `branch_taken`: PC<=branch_target & 16'hFFFE; if_valid<=0 (word at old PC squashed). IR content don't-care.
  - `jump`: PC<=jump_target & 16'hFFFE; if_valid<=0.
  - `stall`: PC, IR, if_pc, if_valid held unchanged.
  - else: IR<=imem_instr, if_pc<=PC, if_valid<=1, PC<=PC+2 (mod 2^16; 16'hFFFE wraps to 16'h0000).
- Redirect beats stall: redirect during stall loads target and clears if_valid.
- Targets with bit0=1 are force-aligned (bit0 cleared); no error flag.
- HALT: in the normal-capture branch, if imem_instr[15:12]==HALT_OPCODE, IR captures it with if_valid=1, PC is NOT advanced, state<=HALTED. A redirect in the same cycle wins: HALT squashed, state stays RUN.
- HALTED: halted=1; PC frozen; if_valid<=0 from the next edge after entry onward (HALT delivered for exactly one cycle unless stall asserted, in which case it is held while stall=1). Redirect inputs ignored. Exit only by reset.
- if_pc_plus2 always equals if_pc+2 (mod 2^16), derived from the register.

## Timing
- imem_addr is PC directly (no combinational path from any input to imem_addr).
- Fetch latency: word at address A appears on if_instr one edge after PC=A with no stall/redirect.
- First valid instruction: first rising edge with rst_n=1 captures mem[RESET_PC]; if_valid=1 after that edge.
- Redirect penalty: one bubble (if_valid=0 for one cycle), target word valid on the edge after that.
- Throughput: one instruction per cycle when stall=0 and no redirect.
- All outputs registered; `stall`, `branch_taken`, `jump` sampled only at the rising edge.

## Test plan
- Reset + sequential: memory holds 16'h1111,2222,3333,4444 at 0,2,4,6; release rst_n -> if_instr 1111/2222/3333/4444 on successive cycles, if_pc 0/2/4/6, if_valid=1, imem_addr 2/4/6/8.
- Stall: assert stall for 2 cycles while if_instr=16'h2222 -> if_instr, if_pc=0002, imem_addr=0004 held; after release 16'h3333 follows with no loss or duplication.
- Redirect: at PC=0004 assert branch_taken, branch_target=16'h0011, and jump=1, jump_target=16'h0020 -> next imem_addr=16'h0010 (branch priority, bit0 cleared), if_valid=0 one cycle, then mem[0x0010] valid with if_pc=0010.
- Wrap: RESET_PC=16'hFFFC -> if_pc FFFC, FFFE, 0000 consecutive; if_pc_plus2 at FFFE equals 0000.
- HALT: mem[6]=16'hF000 -> if_instr=F000, if_valid=1 one cycle, then halted=1, if_valid=0, imem_addr stays 0006; jump pulses ignored; rst_n=0 returns to PC=RESET_PC, halted=0.
- HALT squash: jump=1 in the cycle imem_instr=16'hF000 -> halted stays 0, PC loads jump_target, if_valid=0 one cycle.
